// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: VGA scanout has priority over the Avalon CPU port, with a tagged 1-cycle read return.
// Define VRAM_STARVE_GUARD_EN to build the streak counter that forces a CPU slot after MAX_STREAK VGA wins.
module vga_vram_arbiter #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_STREAK = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  vga_req,
    input  logic [ADDR_W-1:0]     vga_addr,
    output logic                  vga_gnt,
    output logic                  vga_rvalid,
    output logic [DATA_W-1:0]     vga_rdata,
    input  logic                  avl_read,
    input  logic                  avl_write,
    input  logic [ADDR_W-1:0]     avl_address,
    input  logic [DATA_W-1:0]     avl_writedata,
    input  logic [DATA_W/8-1:0]   avl_byteenable,
    output logic                  avl_waitrequest,
    output logic [DATA_W-1:0]     avl_readdata,
    output logic                  avl_readdatavalid,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_be,
    output logic                  ram_we,
    input  logic [DATA_W-1:0]     ram_rdata
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_CPU  = 2'b01,
        TAG_VGA  = 2'b10
    } tag_t;

    if ((DATA_W % 8) != 0 || MAX_STREAK == 0) begin : g_bad_cfg
        $error("vga_vram_arbiter: DATA_W must be a multiple of 8 and MAX_STREAK nonzero");
    end

    logic              ready;
    logic              cpu_req;
    logic              cpu_gnt;
    logic              force_cpu;
    tag_t              tag_q;
    tag_t              tag_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] vga_hold;
    logic [DATA_W-1:0] cpu_hold;

    assign cpu_req = avl_read | avl_write;

`ifdef VRAM_STARVE_GUARD_EN
    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
    logic [STREAK_W-1:0] streak;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak <= '0;
        end else if (cpu_gnt || !cpu_req) begin
            streak <= '0;
        end else if (vga_gnt && streak != STREAK_W'(MAX_STREAK)) begin
            streak <= streak + 1'b1;
        end
    end

    assign force_cpu = (streak == STREAK_W'(MAX_STREAK));
`else
    assign force_cpu = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready <= 1'b0;
        end else begin
            ready <= 1'b1;
        end
    end

    always_comb begin
        cpu_gnt = ready & cpu_req & (~vga_req | force_cpu);
        vga_gnt = ready & vga_req & ~cpu_gnt;
    end

    assign avl_waitrequest = ~cpu_gnt | ~ready;

    // ram_addr falls back to the last granted address so the RAM input stays stable when idle
    always_comb begin
        ram_addr  = addr_q;
        ram_wdata = '0;
        ram_be    = '0;
        ram_we    = 1'b0;
        tag_d     = TAG_NONE;
        if (cpu_gnt) begin
            ram_addr  = avl_address;
            ram_wdata = avl_writedata;
            ram_be    = avl_byteenable;
            ram_we    = avl_write;
            tag_d     = avl_read ? TAG_CPU : TAG_NONE;
        end else if (vga_gnt) begin
            ram_addr  = vga_addr;
            tag_d     = TAG_VGA;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q    <= TAG_NONE;
            addr_q   <= '0;
            vga_hold <= '0;
            cpu_hold <= '0;
        end else begin
            tag_q  <= tag_d;
            addr_q <= ram_addr;
            if (tag_q == TAG_VGA) begin
                vga_hold <= ram_rdata;
            end
            if (tag_q == TAG_CPU) begin
                cpu_hold <= ram_rdata;
            end
        end
    end

    // RAM output is already registered, so data is forwarded in the valid cycle and held afterwards
    assign vga_rvalid        = (tag_q == TAG_VGA);
    assign avl_readdatavalid = (tag_q == TAG_CPU);
    assign vga_rdata         = vga_rvalid ? ram_rdata : vga_hold;
    assign avl_readdata      = avl_readdatavalid ? ram_rdata : cpu_hold;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Self-checking bench for vga_vram_arbiter: directed scenarios plus random traffic against a history-based model.
module tb_vga_vram_arbiter;
    localparam int unsigned ADDR_W     = 11;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BE_W       = DATA_W / 8;
    localparam int unsigned MAX_STREAK = 8;
    localparam int unsigned DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    logic              avl_read;
    logic              avl_write;
    logic [ADDR_W-1:0] avl_address;
    logic [DATA_W-1:0] avl_writedata;
    logic [BE_W-1:0]   avl_byteenable;
    logic              avl_waitrequest;
    logic [DATA_W-1:0] avl_readdata;
    logic              avl_readdatavalid;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [BE_W-1:0]   ram_be;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata = '0;

    vga_vram_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_STREAK(MAX_STREAK)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .vga_req          (vga_req),
        .vga_addr         (vga_addr),
        .vga_gnt          (vga_gnt),
        .vga_rvalid       (vga_rvalid),
        .vga_rdata        (vga_rdata),
        .avl_read         (avl_read),
        .avl_write        (avl_write),
        .avl_address      (avl_address),
        .avl_writedata    (avl_writedata),
        .avl_byteenable   (avl_byteenable),
        .avl_waitrequest  (avl_waitrequest),
        .avl_readdata     (avl_readdata),
        .avl_readdatavalid(avl_readdatavalid),
        .ram_addr         (ram_addr),
        .ram_wdata        (ram_wdata),
        .ram_be           (ram_be),
        .ram_we           (ram_we),
        .ram_rdata        (ram_rdata)
    );

    always #5 clk = ~clk;

    // M9K-style VRAM: registered read of the old contents, byte-masked write
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        for (int b = 0; b < BE_W; b++) begin
            if (ram_we && ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: shadow memory, expected returns one cycle after each grant, and a
    // sliding window of the last MAX_STREAK cycles recording "VGA won while the CPU waited".
    logic [DATA_W-1:0] ref_mem [DEPTH] = '{default: '0};
    bit                starved_win [$];
    bit                rdy_m = 1'b0;
    bit                pend_v = 1'b0;
    bit                pend_c = 1'b0;
    logic [DATA_W-1:0] pend_vd = '0;
    logic [DATA_W-1:0] pend_cd = '0;
    logic [DATA_W-1:0] hold_v = '0;
    logic [DATA_W-1:0] hold_c = '0;
    logic [ADDR_W-1:0] last_addr = '0;

    always @(negedge clk) begin
        bit creq;
        bit forced;
        bit eg_v;
        bit eg_c;
        if (!reset_n) begin
            check("rst_waitrequest", avl_waitrequest, 1);
            check("rst_vga_rvalid", vga_rvalid, 0);
            check("rst_avl_rvalid", avl_readdatavalid, 0);
            check("rst_vga_gnt", vga_gnt, 0);
            check("rst_ram_we", ram_we, 0);
            rdy_m = 1'b0;
            pend_v = 1'b0;
            pend_c = 1'b0;
            hold_v = '0;
            hold_c = '0;
            last_addr = '0;
            starved_win.delete();
        end else begin
            check("vga_rvalid", vga_rvalid, pend_v);
            check("vga_rdata", vga_rdata, pend_v ? pend_vd : hold_v);
            if (pend_v) hold_v = pend_vd;
            check("avl_readdatavalid", avl_readdatavalid, pend_c);
            check("avl_readdata", avl_readdata, pend_c ? pend_cd : hold_c);
            if (pend_c) hold_c = pend_cd;

            creq = avl_read | avl_write;
            forced = 1'b0;
`ifdef VRAM_STARVE_GUARD_EN
            if (creq && starved_win.size() == MAX_STREAK) begin
                forced = 1'b1;
                foreach (starved_win[i]) if (!starved_win[i]) forced = 1'b0;
            end
`endif
            eg_c = rdy_m && creq && (!vga_req || forced);
            eg_v = rdy_m && vga_req && !eg_c;

            check("vga_gnt", vga_gnt, eg_v);
            check("avl_waitrequest", avl_waitrequest, !eg_c);
            check("ram_we", ram_we, eg_c && avl_write);
            check("ram_be", ram_be, eg_c ? avl_byteenable : '0);
            check("ram_addr", ram_addr, eg_c ? avl_address : (eg_v ? vga_addr : last_addr));
            if (eg_c && avl_write) check("ram_wdata", ram_wdata, avl_writedata);

            if (eg_c) last_addr = avl_address;
            else if (eg_v) last_addr = vga_addr;
            pend_v  = eg_v;
            pend_vd = ref_mem[vga_addr];
            pend_c  = eg_c && avl_read;
            pend_cd = ref_mem[avl_address];
            if (eg_c && avl_write) begin
                for (int b = 0; b < BE_W; b++)
                    if (avl_byteenable[b]) ref_mem[avl_address][8*b +: 8] = avl_writedata[8*b +: 8];
            end
            starved_win.push_back(eg_v && creq);
            if (starved_win.size() > MAX_STREAK) void'(starved_win.pop_front());
            rdy_m = 1'b1;
        end
    end

    task automatic go_idle();
        vga_req   = 1'b0;
        avl_read  = 1'b0;
        avl_write = 1'b0;
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        bit ok;
        @(posedge clk); #1;
        avl_write = 1'b1; avl_read = 1'b0;
        avl_address = a; avl_writedata = d; avl_byteenable = be;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!avl_waitrequest) begin ok = 1'b1; break; end
        end
        check("wr_accept", ok, 1);
        @(posedge clk); #1;
        avl_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        bit ok;
        @(posedge clk); #1;
        avl_read = 1'b1; avl_write = 1'b0; avl_address = a;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!avl_waitrequest) begin ok = 1'b1; break; end
        end
        check("rd_accept", ok, 1);
        @(posedge clk); #1;
        avl_read = 1'b0;
        @(negedge clk);
        check("rd_valid", avl_readdatavalid, 1);
        check("rd_data", avl_readdata, exp);
    endtask

    initial begin
        int unsigned ncpu;
        int unsigned a;
        int unsigned op;
        reset_n = 1'b0;
        vga_req = 1'b0; vga_addr = '0;
        avl_read = 1'b1; avl_write = 1'b0;
        avl_address = '0; avl_writedata = '0; avl_byteenable = '0;

        // Reset with a pending CPU read; ready needs one clock before the first grant
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("ready_first_cycle_wait", avl_waitrequest, 1);
        @(negedge clk);
        check("first_grant_2nd_clock", avl_waitrequest, 0);
        @(posedge clk); #1;
        avl_read = 1'b0;

        // CPU-only write with partial byte enables, then read back
        cpu_write(ADDR_W'(16), 32'hDEADBEEF, 4'b0011);
        cpu_read(ADDR_W'(16), 32'h0000BEEF);

        // Back-to-back read then write of the same word returns pre-write data
        @(posedge clk); #1;
        avl_read = 1'b1; avl_address = ADDR_W'(16);
        @(negedge clk);
        check("zero_wait_read", avl_waitrequest, 0);
        @(posedge clk); #1;
        avl_read = 1'b0; avl_write = 1'b1;
        avl_writedata = 32'h12345678; avl_byteenable = 4'hF;
        @(negedge clk);
        check("rbw_valid", avl_readdatavalid, 1);
        check("rbw_data", avl_readdata, 32'h0000BEEF);
        check("zero_wait_write", avl_waitrequest, 0);
        @(posedge clk); #1;
        avl_write = 1'b0;
        cpu_read(ADDR_W'(16), 32'h12345678);

        // Contention: both requesters held continuously
        @(posedge clk); #1;
        vga_req = 1'b1; avl_read = 1'b1;
        vga_addr = ADDR_W'($urandom_range(0, 31));
        avl_address = ADDR_W'($urandom_range(0, 31));
        ncpu = 0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (!avl_waitrequest) ncpu++;
            @(posedge clk); #1;
            vga_addr = ADDR_W'($urandom_range(0, 31));
            avl_address = ADDR_W'($urandom_range(0, 31));
        end
`ifdef VRAM_STARVE_GUARD_EN
        check("contention_cpu_grants", ncpu, 36 / (MAX_STREAK + 1));
`else
        check("contention_cpu_grants", ncpu, 0);
`endif
        vga_req = 1'b0;
        @(negedge clk);
        check("cpu_after_vga_drop", avl_waitrequest, 0);
        @(posedge clk); #1;
        go_idle();

        // Interleave: fill 0..15, then VGA on even cycles against a CPU read stream
        for (int i = 0; i < 16; i++) cpu_write(ADDR_W'(i), $urandom, 4'hF);
        a = 0;
        for (int c = 0; c < 80 && a < 16; c++) begin
            @(posedge clk); #1;
            vga_req = (c % 2 == 0);
            vga_addr = ADDR_W'($urandom_range(0, 15));
            avl_read = 1'b1;
            avl_address = ADDR_W'(a);
            @(negedge clk);
            if (!avl_waitrequest) a++;
        end
        check("interleave_reads_done", a, 16);
        @(posedge clk); #1;
        go_idle();

        // Random traffic, light then heavy VGA load
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            vga_req = ($urandom_range(0, 99) < ((c < 1500) ? 60 : 95));
            vga_addr = ADDR_W'($urandom_range(0, 31));
            op = $urandom_range(0, 2);
            avl_read = (op == 1);
            avl_write = (op == 2);
            avl_address = ADDR_W'($urandom_range(0, 31));
            avl_writedata = $urandom;
            avl_byteenable = BE_W'($urandom_range(0, 15));
        end
        @(posedge clk); #1;
        go_idle();

        // Reset right after a VGA grant: tag dropped, outputs back to reset values
        @(posedge clk); #1;
        vga_req = 1'b1; vga_addr = ADDR_W'(3);
        @(negedge clk);
        check("pre_reset_vga_gnt", vga_gnt, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_vga_rvalid", vga_rvalid, 0);
        check("async_rst_vga_rdata", vga_rdata, 0);
        check("async_rst_avl_rvalid", avl_readdatavalid, 0);
        check("async_rst_avl_rdata", avl_readdata, 0);
        check("async_rst_waitrequest", avl_waitrequest, 1);
        check("async_rst_vga_gnt", vga_gnt, 0);
        check("async_rst_ram_addr", ram_addr, 0);
        check("async_rst_ram_be", ram_be, 0);
        check("async_rst_ram_we", ram_we, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        vga_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule

// File: doc/vga_vram_arbiter.md
# vga_vram_arbiter

Arbiter and sequencer for the single-port on-chip video RAM shared by the VGA scanout engine and the NIOS II Avalon-MM data master. It sits between the `lab7_soc` Avalon fabric, the VGA text/pixel controller and one M9K-based VRAM instance. VGA fetches have priority so the display never tears. A starvation guard guarantees the CPU forward progress. Read data is returned to the correct requester through a latency-matched tag pipeline.

## Interface
- `ADDR_W`, 11, VRAM word address width
- `DATA_W`, 32, VRAM word width; must be a multiple of 8
- `MAX_STREAK`, 8, consecutive VGA grants allowed while the CPU waits (guard enabled only)
- `clk`  in  1  system clock (50 MHz)
- `reset_n`  in  1  asynchronous, active-low reset
- `vga_req`  in  1  VGA fetch request; level, held until granted
- `vga_addr`  in  ADDR_W  VGA fetch word address
- `vga_gnt`  out  1  VGA request accepted this cycle
- `vga_rvalid`  out  1  `vga_rdata` valid
- `vga_rdata`  out  DATA_W  VGA fetch data
- `avl_read`, `avl_write`  in  1  Avalon-MM slave commands; never both high
- `avl_address`  in  ADDR_W  Avalon word address
- `avl_writedata`  in  DATA_W  write data
- `avl_byteenable`  in  DATA_W/8  write byte enables
- `avl_waitrequest`  out  1  command not accepted this cycle
- `avl_readdata`  out  DATA_W  read data
- `avl_readdatavalid`  out  1  `avl_readdata` valid
- `ram_addr`  out  ADDR_W  VRAM address
- `ram_wdata`  out  DATA_W  VRAM write data
- `ram_be`  out  DATA_W/8  VRAM byte enables
- `ram_we`  out  1  VRAM write strobe
- `ram_rdata`  in  DATA_W  VRAM read data; registered, valid 1 cycle after the address

## Operation
- One grant per cycle at most. The grant is combinational from the requests and the registered state.
- Priority: VGA over CPU. When the guard forces a CPU slot, CPU wins that cycle.
- `cpu_req = avl_read | avl_write`. `avl_waitrequest = ~cpu_gnt | ~ready`, where `ready` is a flop cleared by reset and set on the first clock after reset deasserts.
- Outputs driven on a VGA grant: `ram_addr = vga_addr`, `ram_we = 0`.
- Outputs driven on a CPU grant: `ram_addr = avl_address`, `ram_we = avl_write`, `ram_wdata`/`ram_be` from Avalon.
- When no grant is given: `ram_we = 0`, `ram_be = 0`, and `ram_addr` holds its last value.
- Tag pipeline: a 2-bit register {vga, cpu_read} is loaded each cycle with the grant type. A CPU write loads 00.
- In the cycle after a grant, `ram_rdata` is routed to `vga_rdata` with `vga_rvalid` pulsed, or to `avl_readdata` with `avl_readdatavalid` pulsed.
- Data outputs are registered copies of `ram_rdata` and hold between valids.
- Streak counter (`$clog2(MAX_STREAK+1)` bits):
  - increments on each VGA grant while `cpu_req` is high;
  - clears on any CPU grant or when `cpu_req` is low;
  - saturates at `MAX_STREAK`.
- At `MAX_STREAK` the next cycle is forced to a CPU grant, whatever `vga_req` is.

## Timing
- Reset values: all outputs 0 except `avl_waitrequest = 1`; tag and streak registers 0.
- Async reset mid-transaction drops any in-flight tag: no valid pulse follows reset.
- Grant to data: exactly 1 cycle for both requesters. Throughput is 1 access per cycle.
- A CPU write completes in the grant cycle.
- Simultaneous `vga_req` and `cpu_req` with streak < `MAX_STREAK`: VGA is granted and `avl_waitrequest = 1`.
- Back-to-back CPU read then write to the same address: the read returns the pre-write data.
- `vga_req` low with `cpu_req` high: CPU is granted in the same cycle, with zero-wait Avalon.

## Configuration
- `VRAM_STARVE_GUARD_EN` defined: the streak counter and forced CPU slot are built as described.
- Not defined: strict VGA priority. No counter is built, and the CPU waits for as long as `vga_req` is held high.

## Test plan
- Reset: hold `reset_n` low with `avl_read = 1` -> `avl_waitrequest = 1`, all valids 0; first grant occurs on the 2nd clock after release.
- CPU-only: write 0xDEADBEEF to addr 0x10 with be = 4'b0011, then read 0x10 -> `avl_readdatavalid` 1 cycle after accept, data = 0x0000BEEF (RAM pre-cleared).
- Contention: `vga_req` and `avl_read` both held -> 8 VGA grants, then 1 CPU grant, repeating; reads return correct data.
- Without `VRAM_STARVE_GUARD_EN`: same stimulus -> `avl_waitrequest` stays 1 until `vga_req` drops.
- Interleave: alternate `vga_req` on even cycles with a continuous CPU read stream over addresses 0..15 -> every `vga_rvalid` and `avl_readdatavalid` matches its own address, and no valid is lost or duplicated.
- Reset asserted 1 cycle after a VGA grant -> no `vga_rvalid` pulse; all outputs return to their reset values immediately.
